// File: rtl/systolic_array_sparse_pkg.sv
// Shared dimensions and indexing helpers for the sparse weight-stationary array.
package systolic_array_sparse_pkg;

    localparam int N_ROWS_DEF = 8;
    localparam int N_COLS_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;

    // Bit offset of PE(r,c)'s accumulator inside the flattened output bus.
    function automatic int cout_idx(input int r, input int c, input int n_cols, input int acc_w);
        return (r * n_cols + c) * acc_w;
    endfunction

endpackage

// File: rtl/systolic_array_sparse_pe.sv
// One array cell: stationary weight, zero-skipping MAC and activation forwarding.
module sparse_mac_pe
    import systolic_array_sparse_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [DATA_W-1:0] w_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] w_out,
    output logic [DATA_W-1:0] a_out,
    output logic              valid_out,
    output logic [ACC_W-1:0]  acc_out
);

    logic [DATA_W-1:0]          w_q;
    logic [DATA_W-1:0]          a_q;
    logic                       v_q;
    logic [ACC_W-1:0]           acc_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic                       do_mac;

    assign prod     = $signed(a_in) * $signed(w_q);
    assign prod_ext = ACC_W'(prod);
    // A loading cell never accumulates; zero operands leave acc untouched.
    assign do_mac   = valid_in && !load_en && (a_in != '0) && (w_q != '0);

    // Weight register shifts down the column while the skewed load is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       w_q <= '0;
        else if (load_en) w_q <= w_in;
    end

    // Accumulator wraps modulo 2^ACC_W; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      acc_q <= '0;
        else if (do_mac) acc_q <= acc_q + prod_ext;
    end

    // Activation and valid forward east every cycle, independent of the skip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            v_q <= 1'b0;
        end else begin
            a_q <= a_in;
            v_q <= valid_in;
        end
    end

    assign w_out     = w_q;
    assign a_out     = a_q;
    assign valid_out = v_q;
    assign acc_out   = acc_q;

endmodule

// File: rtl/systolic_array_sparse.sv
// Weight-stationary sparse MAC grid with per-column load/weight skew chains.
module systolic_array_sparse
    import systolic_array_sparse_pkg::*;
#(
    parameter int N_ROWS = N_ROWS_DEF,
    parameter int N_COLS = N_COLS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             block_valid,
    input  logic                             load_weight,
    input  logic [N_ROWS*DATA_W-1:0]         a_in_flat,
    input  logic [N_COLS*DATA_W-1:0]         b_in_flat,
    output logic [N_ROWS*N_COLS*ACC_W-1:0]   c_out_flat
);

    logic [N_COLS-1:0]                         ld_col;
    logic [N_COLS-1:0][DATA_W-1:0]             b_col;
    logic [N_ROWS-1:0][N_COLS-1:0][DATA_W-1:0] w_g;
    logic [N_ROWS-1:0][N_COLS-1:0][DATA_W-1:0] a_g;
    logic [N_ROWS-1:0][N_COLS-1:0]             v_g;
    logic [N_ROWS-1:0]                         unused_east;
    logic                                      unused_south;

    // Column c sees load_weight and its weight lane c cycles late, matching
    // the diagonal wavefront of activations so loads and computes line up.
    for (genvar gc = 0; gc < N_COLS; gc++) begin : g_skew
        if (gc == 0) begin : g_direct
            assign ld_col[gc] = load_weight;
            assign b_col[gc]  = b_in_flat[gc*DATA_W +: DATA_W];
        end else begin : g_chain
            logic [gc-1:0]             ld_q;
            logic [gc-1:0][DATA_W-1:0] b_q;
            // Delay line of depth gc for the load strobe and weight lane.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ld_q <= '0;
                    b_q  <= '0;
                end else begin
                    ld_q[0] <= load_weight;
                    b_q[0]  <= b_in_flat[gc*DATA_W +: DATA_W];
                    for (int k = 1; k < gc; k++) begin
                        ld_q[k] <= ld_q[k-1];
                        b_q[k]  <= b_q[k-1];
                    end
                end
            end
            assign ld_col[gc] = ld_q[gc-1];
            assign b_col[gc]  = b_q[gc-1];
        end
    end

    for (genvar gr = 0; gr < N_ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < N_COLS; gc++) begin : g_col
            logic [DATA_W-1:0] w_src;
            logic [DATA_W-1:0] a_src;
            logic              v_src;

            if (gr == 0) begin : g_wtop
                assign w_src = b_col[gc];
            end else begin : g_wchain
                assign w_src = w_g[gr-1][gc];
            end

            if (gc == 0) begin : g_aedge
                assign a_src = a_in_flat[gr*DATA_W +: DATA_W];
                assign v_src = block_valid;
            end else begin : g_achain
                assign a_src = a_g[gr][gc-1];
                assign v_src = v_g[gr][gc-1];
            end

            sparse_mac_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk       (clk),
                .rst_n     (rst_n),
                .load_en   (ld_col[gc]),
                .w_in      (w_src),
                .a_in      (a_src),
                .valid_in  (v_src),
                .w_out     (w_g[gr][gc]),
                .a_out     (a_g[gr][gc]),
                .valid_out (v_g[gr][gc]),
                .acc_out   (c_out_flat[cout_idx(gr, gc, N_COLS, ACC_W) +: ACC_W])
            );
        end
        // Forwarding outputs past the east edge have no consumer.
        assign unused_east[gr] = ^{a_g[gr][N_COLS-1], v_g[gr][N_COLS-1]};
    end

    // Weights shifted out of the bottom row are dropped.
    assign unused_south = ^w_g[N_ROWS-1];

    // Driving compute and load in the same cycle is a caller error.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(block_valid && load_weight))
            else $warning("block_valid and load_weight asserted together");
        end
    end

endmodule

// File: tb/tb_systolic_array_sparse.sv
// Randomised and directed bench for systolic_array_sparse against a wavefront model.
module tb_systolic_array_sparse;

    localparam int NR  = 8;
    localparam int NC  = 8;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int AWN = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  block_valid = 1'b0;
    logic                  load_weight = 1'b0;
    logic [NR*DW-1:0]      a_in_flat = '0;
    logic [NC*DW-1:0]      b_in_flat = '0;
    logic [NR*NC*AW-1:0]   c_out_flat;
    logic [NR*NC*AWN-1:0]  c_out_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_array_sparse #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .block_valid(block_valid), .load_weight(load_weight),
        .a_in_flat(a_in_flat), .b_in_flat(b_in_flat), .c_out_flat(c_out_flat));

    // Narrow-accumulator instance makes wrap-around reachable in few cycles.
    systolic_array_sparse #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(AWN)) dut_n (
        .clk(clk), .rst_n(rst_n), .block_valid(block_valid), .load_weight(load_weight),
        .a_in_flat(a_in_flat), .b_in_flat(b_in_flat), .c_out_flat(c_out_n));

    // Reference: column c acts on the inputs presented c cycles earlier.
    logic signed [AW-1:0] m_acc [NR][NC];
    logic signed [DW-1:0] m_w   [NR][NC];
    logic                 h_v   [NC];
    logic                 h_l   [NC];
    logic [NR*DW-1:0]     h_a   [NC];
    logic [NC*DW-1:0]     h_b   [NC];
    logic signed [DW-1:0] wl    [NR][NC];

    function automatic logic signed [AW-1:0] dut_acc(input int r, input int c);
        return c_out_flat[(r*NC+c)*AW +: AW];
    endfunction

    function automatic logic signed [AWN-1:0] dut_accn(input int r, input int c);
        return c_out_n[(r*NC+c)*AWN +: AWN];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                m_acc[r][c] = '0;
                m_w[r][c]   = '0;
            end
        for (int k = 0; k < NC; k++) begin
            h_v[k] = 1'b0; h_l[k] = 1'b0; h_a[k] = '0; h_b[k] = '0;
        end
    endtask

    task automatic model_edge();
        logic signed [DW-1:0] av;
        for (int k = NC-1; k > 0; k--) begin
            h_v[k] = h_v[k-1]; h_l[k] = h_l[k-1]; h_a[k] = h_a[k-1]; h_b[k] = h_b[k-1];
        end
        h_v[0] = block_valid; h_l[0] = load_weight; h_a[0] = a_in_flat; h_b[0] = b_in_flat;
        for (int c = 0; c < NC; c++) begin
            if (h_l[c]) begin
                for (int r = NR-1; r > 0; r--) m_w[r][c] = m_w[r-1][c];
                m_w[0][c] = h_b[c][c*DW +: DW];
            end else if (h_v[c]) begin
                for (int r = 0; r < NR; r++) begin
                    av = h_a[c][r*DW +: DW];
                    if (av != 0 && m_w[r][c] != 0)
                        m_acc[r][c] = m_acc[r][c] + av * m_w[r][c];
                end
            end
        end
    endtask

    task automatic tick(input logic bv, input logic lw,
                        input logic [NR*DW-1:0] a, input logic [NC*DW-1:0] b);
        block_valid = bv; load_weight = lw; a_in_flat = a; b_in_flat = b;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        idle(5);
        rst_n = 1'b1;
    endtask

    // Shift wl[0..NR-1] in on consecutive cycles, then let the skew drain.
    task automatic do_load();
        logic [NC*DW-1:0] b;
        for (int i = 0; i < NR; i++) begin
            for (int c = 0; c < NC; c++) b[c*DW +: DW] = wl[i][c];
            tick(1'b0, 1'b1, '0, b);
        end
        idle(NC + 2);
    endtask

    task automatic fill_wl(input int v);
        for (int i = 0; i < NR; i++)
            for (int c = 0; c < NC; c++) wl[i][c] = DW'(v);
    endtask

    task automatic test_reset();
        logic [NR*DW-1:0] a;
        apply_reset();
        checks++;
        if (c_out_flat !== '0) begin
            errors++; $display("FAIL reset_main got %h want 0", c_out_flat[63:0]);
        end
        checks++;
        if (c_out_n !== '0) begin
            errors++; $display("FAIL reset_narrow got %h want 0", c_out_n[63:0]);
        end
        for (int i = 0; i < NR; i++)
            for (int c = 0; c < NC; c++) wl[i][c] = DW'($urandom_range(1, 255));
        do_load();
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < NR; r++) a[r*DW +: DW] = DW'($urandom);
            tick(1'b1, 1'b0, a, '0);
        end
        idle(NC);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dut_acc(r, c) !== m_acc[r][c]) begin
                    errors++;
                    $display("FAIL pre_reset pe(%0d,%0d) got %0d want %0d", r, c, dut_acc(r, c), m_acc[r][c]);
                end
            end
        // Start a load, then drop reset between clock edges.
        tick(1'b0, 1'b1, '0, {NC{8'h55}});
        tick(1'b0, 1'b1, '0, {NC{8'h66}});
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (c_out_flat !== '0) begin
            errors++; $display("FAIL async_reset got %h want 0", c_out_flat[63:0]);
        end
        model_reset();
        idle(5);
        rst_n = 1'b1;
        // Weights must be cleared too: compute now leaves every acc at zero.
        for (int t = 0; t < 10; t++) tick(1'b1, 1'b0, {NR{8'h7f}}, '0);
        idle(NC);
        checks++;
        if (c_out_flat !== '0) begin
            errors++; $display("FAIL reset_weights got %h want 0", c_out_flat[63:0]);
        end
    endtask

    task automatic test_distinct();
        logic [NR*DW-1:0] a;
        apply_reset();
        for (int i = 0; i < NR; i++)
            for (int c = 0; c < NC; c++) wl[i][c] = DW'(i*8 + c + 1);
        do_load();
        for (int t = 0; t < 16; t++) begin
            for (int j = 0; j < NR; j++) a[j*DW +: DW] = (t >= j && t <= j + 7) ? 8'd1 : 8'd0;
            tick(1'b1, 1'b0, a, '0);
        end
        idle(NC);
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (dut_acc(0, c) !== 32'(8 * (57 + c))) begin
                errors++; $display("FAIL distinct_row0 c=%0d got %0d want %0d", c, dut_acc(0, c), 8*(57+c));
            end
        end
        checks++;
        if (dut_acc(0, 0) !== 456 || dut_acc(0, 3) !== 480) begin
            errors++; $display("FAIL distinct_corner got %0d/%0d want 456/480", dut_acc(0, 0), dut_acc(0, 3));
        end
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dut_acc(r, c) !== m_acc[r][c]) begin
                    errors++;
                    $display("FAIL distinct pe(%0d,%0d) got %0d want %0d", r, c, dut_acc(r, c), m_acc[r][c]);
                end
            end
    endtask

    task automatic test_uniform();
        apply_reset();
        fill_wl(2);
        do_load();
        for (int t = 0; t < 16; t++) tick(1'b1, 1'b0, {NR{8'd1}}, '0);
        checks++;
        if (dut_acc(0, 0) !== 32) begin
            errors++; $display("FAIL uniform_first got %0d want 32", dut_acc(0, 0));
        end
        idle(NC - 1);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dut_acc(r, c) !== 32) begin
                    errors++; $display("FAIL uniform pe(%0d,%0d) got %0d want 32", r, c, dut_acc(r, c));
                end
            end
    endtask

    task automatic test_negative();
        apply_reset();
        fill_wl(-3);
        do_load();
        for (int t = 0; t < 16; t++) tick(1'b1, 1'b0, {NR{8'd2}}, '0);
        idle(NC - 1);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dut_acc(r, c) !== -96) begin
                    errors++; $display("FAIL negative pe(%0d,%0d) got %0d want -96", r, c, dut_acc(r, c));
                end
            end
    endtask

    task automatic test_zero_skip();
        logic [NR*DW-1:0] a;
        apply_reset();
        for (int i = 0; i < NR; i++)
            for (int c = 0; c < NC; c++) wl[i][c] = (c == 2) ? 8'sd0 : DW'($urandom_range(1, 255));
        do_load();
        for (int t = 0; t < 12; t++) begin
            for (int r = 0; r < NR; r++) a[r*DW +: DW] = (r == 1) ? 8'd0 : DW'($urandom_range(1, 255));
            tick(1'b1, 1'b0, a, '0);
        end
        idle(NC);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                checks++;
                if ((r == 1 || c == 2) && dut_acc(r, c) !== 0) begin
                    errors++; $display("FAIL zero_skip_zero pe(%0d,%0d) got %0d want 0", r, c, dut_acc(r, c));
                end else if (dut_acc(r, c) !== m_acc[r][c]) begin
                    errors++;
                    $display("FAIL zero_skip pe(%0d,%0d) got %0d want %0d", r, c, dut_acc(r, c), m_acc[r][c]);
                end
            end
    endtask

    task automatic test_random_back_to_back();
        logic [NR*DW-1:0] a;
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NR; i++)
                for (int c = 0; c < NC; c++)
                    wl[i][c] = ($urandom_range(0, 3) == 0) ? 8'sd0 : DW'($urandom);
            do_load();
            for (int t = 0; t < 30; t++) begin
                for (int r = 0; r < NR; r++)
                    a[r*DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'd0 : DW'($urandom);
                tick($urandom_range(0, 9) < 7, 1'b0, a, '0);
            end
            idle(NC);
        end
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dut_acc(r, c) !== m_acc[r][c]) begin
                    errors++;
                    $display("FAIL random pe(%0d,%0d) got %0d want %0d", r, c, dut_acc(r, c), m_acc[r][c]);
                end
            end
    endtask

    task automatic test_overflow();
        apply_reset();
        fill_wl(127);
        do_load();
        for (int t = 0; t < 3; t++) tick(1'b1, 1'b0, {NR{8'd127}}, '0);
        idle(NC);
        checks++;
        if (dut_acc(0, 0) !== 48387) begin
            errors++; $display("FAIL overflow_wide got %0d want 48387", dut_acc(0, 0));
        end
        checks++;
        if (dut_accn(0, 0) !== -17149) begin
            errors++; $display("FAIL overflow_wrap got %0d want -17149", dut_accn(0, 0));
        end
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dut_accn(r, c) !== m_acc[r][c][AWN-1:0]) begin
                    errors++;
                    $display("FAIL overflow_narrow pe(%0d,%0d) got %0d want %0d", r, c, dut_accn(r, c), $signed(m_acc[r][c][AWN-1:0]));
                end
            end
    endtask

    task automatic test_illegal();
        logic [NR*DW-1:0]     a;
        logic signed [AW-1:0] col0 [NR];
        apply_reset();
        for (int i = 0; i < NR; i++)
            for (int c = 0; c < NC; c++) wl[i][c] = DW'($urandom_range(1, 255));
        do_load();
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < NR; r++) a[r*DW +: DW] = DW'($urandom_range(1, 255));
            tick(1'b1, 1'b0, a, '0);
        end
        for (int r = 0; r < NR; r++) col0[r] = m_acc[r][0];
        tick(1'b1, 1'b1, {NR{8'd9}}, {NC{8'd5}});
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (dut_acc(r, 0) !== col0[r]) begin
                errors++; $display("FAIL illegal_col0 r=%0d got %0d want %0d", r, dut_acc(r, 0), col0[r]);
            end
        end
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < NR; r++) a[r*DW +: DW] = DW'($urandom_range(1, 255));
            tick(1'b1, 1'b0, a, '0);
        end
        idle(NC);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dut_acc(r, c) !== m_acc[r][c]) begin
                    errors++;
                    $display("FAIL illegal pe(%0d,%0d) got %0d want %0d", r, c, dut_acc(r, c), m_acc[r][c]);
                end
            end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_distinct();
        test_uniform();
        test_negative();
        test_zero_skip();
        test_random_back_to_back();
        test_overflow();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
